// File: rtl/tmr_arb_if.sv
`default_nettype none
// =============================================================================
// Module  : tmr_arb_if
// Brief   : Request/delay/grant bundle between requesters and the shared timer.
// Revision: 1.0 - initial release
// =============================================================================
interface tmr_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] delay;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [2:0]               cur_id;

    modport master (
        output req, delay,
        input  grant, done, busy, cur_id
    );

    modport slave (
        input  req, delay,
        output grant, done, busy, cur_id
    );
endinterface
`default_nettype wire

// File: rtl/tmr_arb.sv
`default_nettype none
// =============================================================================
// Module  : tmr_arb
// Brief   : Round-robin arbiter sharing one down-counter among NUM_REQ delays.
// Revision: 1.0 - initial release
// =============================================================================
module tmr_arb #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32
) (
    input  logic       clk,
    input  logic       reset,
    tmr_arb_if.slave   bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] c_one = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   own_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               busy_q;
    logic [2:0]         cur_id_q;

    logic [CNT_W-1:0]   dly [NUM_REQ];
    logic [PTR_W-1:0]   arb_win;
    logic [PTR_W-1:0]   arb_pos;
    logic               arb_vld;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign dly[i] = bus.delay[i*CNT_W +: CNT_W];
    end

    // Scan from farthest to nearest so the nearest set request after ptr wins.
    always_comb begin
        arb_win = '0;
        arb_pos = '0;
        arb_vld = |bus.req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            arb_pos = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (bus.req[arb_pos]) begin
                arb_win = arb_pos;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= PTR_W'(NUM_REQ - 1);
            own_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            cur_id_q <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= '0;
                    if (arb_vld) begin
                        state_q  <= ST_COUNT;
                        ptr_q    <= arb_win;
                        own_q    <= arb_win;
                        cnt_q    <= dly[arb_win];
                        grant_q  <= c_one << arb_win;
                        busy_q   <= 1'b1;
                        cur_id_q <= 3'(arb_win);
                    end
                end
                ST_COUNT: begin
                    if (!bus.req[own_q]) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= c_one << own_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.cur_id = cur_id_q;

endmodule
`default_nettype wire

// File: tb/tb_tmr_arb.sv
`default_nettype none
// =============================================================================
// Module  : tb_tmr_arb
// Brief   : Directed and random stimulus against a cycle-schedule model.
// Revision: 1.0 - initial release
// =============================================================================
module tb_tmr_arb;

    localparam int NR = 4;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tmr_arb_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();

    tmr_arb #(.NUM_REQ(NR), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int     n_cmp = 0;
    int     n_mis = 0;
    longint cyc_n = 0;

    // Model: an ownership is a window [T+1, T+D+2] that a cancel may cut short.
    bit     m_owned = 1'b0;
    int     m_w     = 0;
    int     m_ptr   = NR - 1;
    int     m_cur   = 0;
    longint m_T     = 0;
    longint m_D     = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_mis++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_owned = 1'b0;
            m_ptr   = NR - 1;
            m_cur   = 0;
        end else if (!m_owned) begin
            if (bus.req != '0) begin
                for (int k = 1; k <= NR; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NR;
                    if (bus.req[idx]) begin
                        m_w = idx;
                        break;
                    end
                end
                m_owned = 1'b1;
                m_T     = cyc_n;
                m_D     = longint'(bus.delay[m_w*CW +: CW]);
                m_ptr   = m_w;
                m_cur   = m_w;
            end
        end else begin
            if (cyc_n >= m_T + 1 && cyc_n <= m_T + m_D + 1 && !bus.req[m_w])
                m_owned = 1'b0;
            else if (cyc_n == m_T + m_D + 2)
                m_owned = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [NR-1:0] eg;
        logic [NR-1:0] ed;
        eg = m_owned ? (NR'(1) << m_w) : '0;
        ed = (m_owned && cyc_n == m_T + m_D + 2) ? (NR'(1) << m_w) : '0;
        chk("grant",  32'(bus.grant),  32'(eg));
        chk("done",   32'(bus.done),   32'(ed));
        chk("busy",   32'(bus.busy),   32'(m_owned));
        chk("cur_id", 32'(bus.cur_id), 32'(m_cur));
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        cyc_n++;
        check_outputs();
    endtask

    task automatic run(int k);
        repeat (k) tick();
    endtask

    task automatic set_d(int i, logic [CW-1:0] v);
        bus.delay[i*CW +: CW] = v;
    endtask

    initial begin
        reset     = 1'b1;
        bus.req   = '0;
        bus.delay = '0;
        run(2);
        reset = 1'b0;

        // Single requester, D=3, dropped after done.
        set_d(0, 32'd3);
        bus.req = 4'b0001;
        run(6);
        bus.req = 4'b0000;
        run(3);

        // All four held with D=1: rotating grants.
        for (int i = 0; i < NR; i++) set_d(i, 32'd1);
        bus.req = 4'b1111;
        run(24);
        bus.req = 4'b0000;
        run(4);

        // D=0 boundary.
        set_d(2, 32'd0);
        bus.req = 4'b0100;
        run(3);
        bus.req = 4'b0000;
        run(3);

        // Cancel mid-count, then another requester.
        set_d(1, 32'd10);
        bus.req = 4'b0010;
        run(4);
        bus.req = 4'b0000;
        run(2);
        set_d(3, 32'd2);
        bus.req = 4'b1000;
        run(5);
        bus.req = 4'b0000;
        run(3);

        // Reset during a long count; then req0 and req1 together.
        set_d(1, 32'd20);
        bus.req = 4'b0010;
        run(5);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        set_d(0, 32'd2);
        bus.req = 4'b0011;
        run(12);
        bus.req = 4'b0000;
        run(3);

        // Pending requester whose delay changes while it waits.
        set_d(0, 32'd4);
        set_d(3, 32'd1);
        bus.req = 4'b0001;
        run(2);
        bus.req = 4'b1001;
        run(2);
        set_d(3, 32'd6);
        run(4);
        bus.req = 4'b1000;
        run(10);
        bus.req = 4'b0000;
        run(3);

        // Maximum delay: must keep counting without completing.
        set_d(2, '1);
        bus.req = 4'b0100;
        run(40);
        bus.req = 4'b0000;
        run(3);

        // Random traffic obeying the hold-until-done protocol.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < NR; i++) begin
                if (bus.req[i]) begin
                    if (bus.done[i]) begin
                        if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
                    end else if ($urandom_range(0, 39) == 0) begin
                        bus.req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.req[i] = 1'b1;
                end
                if ($urandom_range(0, 5) == 0) set_d(i, CW'($urandom_range(0, 6)));
            end
            tick();
        end
        reset   = 1'b0;
        bus.req = '0;
        run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
